// File: rtl/rv32i_types.sv
// Shared RV32I types, extended with the burst bridge state encoding and line geometry.
package rv32i_types;

  localparam int BRIDGE_BEATS      = 4;
  localparam int BRIDGE_BEAT_WIDTH = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3,
    DONE  = 3'd4
  } bridge_state_t;

  function automatic int line_offset_bits(input int beats, input int beat_width);
    return $clog2((beats * beat_width) / 8);
  endfunction

  // A single-beat line still needs a one-bit counter so the datapath stays sized.
  function automatic int beat_idx_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int BRIDGE_LINE_BYTES  = (BRIDGE_BEATS * BRIDGE_BEAT_WIDTH) / 8;
  localparam int BRIDGE_OFFSET_BITS = line_offset_bits(BRIDGE_BEATS, BRIDGE_BEAT_WIDTH);
  localparam int BRIDGE_BEAT_IDX_W  = beat_idx_width(BRIDGE_BEATS);

endpackage

// File: rtl/line_buffer.sv
// One cache-line of storage: beat-wide fill port, byte-masked word merge port.
// word_rdata shows the contents including this cycle's writes so the caller can register it.
module line_buffer
  import rv32i_types::*;
#(
  parameter int  BEATS      = BRIDGE_BEATS,
  parameter int  BEAT_WIDTH = BRIDGE_BEAT_WIDTH,
  localparam int LINE_BITS  = BEATS * BEAT_WIDTH,
  localparam int IDX_W      = beat_idx_width(BEATS),
  localparam int WIDX_W     = $clog2(LINE_BITS / 32)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat_we,
  input  logic [IDX_W-1:0]      beat_widx,
  input  logic [BEAT_WIDTH-1:0] beat_wdata,
  input  logic                  merge_en,
  input  logic [WIDX_W-1:0]     word_idx,
  input  logic [31:0]           merge_data,
  input  logic [3:0]            merge_be,
  input  logic [IDX_W-1:0]      beat_ridx,
  output logic [BEAT_WIDTH-1:0] beat_rdata,
  output logic [31:0]           word_rdata
);

  logic [LINE_BITS-1:0] line_q;
  logic [LINE_BITS-1:0] line_d;

  // Next line contents: beat fill first, then the byte-lane merge of the addressed word.
  always_comb begin
    line_d = line_q;
    line_d[int'(beat_widx)*BEAT_WIDTH +: BEAT_WIDTH] =
      beat_we ? beat_wdata : line_q[int'(beat_widx)*BEAT_WIDTH +: BEAT_WIDTH];
    for (int i = 0; i < 4; i++) begin
      line_d[int'(word_idx)*32 + i*8 +: 8] = (merge_en && merge_be[i]) ?
        merge_data[i*8 +: 8] : line_d[int'(word_idx)*32 + i*8 +: 8];
    end
  end

  // Line storage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign beat_rdata = line_q[int'(beat_ridx)*BEAT_WIDTH +: BEAT_WIDTH];
  assign word_rdata = line_d[int'(word_idx)*32 +: 32];

endmodule

// File: rtl/mem_burst_bridge.sv
// Serves the CPU word interface from a line-burst memory: reads fetch the whole line,
// writes read-modify-write the line under byte enables and burst it back.
module mem_burst_bridge
  import rv32i_types::*;
#(
  parameter int BEATS      = BRIDGE_BEATS,
  parameter int BEAT_WIDTH = BRIDGE_BEAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           mem_address,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_byte_enable,
  output logic [31:0]           mem_rdata,
  output logic                  mem_resp,
  output logic [31:0]           burst_address,
  output logic                  burst_read,
  output logic                  burst_write,
  output logic [BEAT_WIDTH-1:0] burst_wdata,
  input  logic [BEAT_WIDTH-1:0] burst_rdata,
  input  logic                  burst_resp
);

  localparam int               OFFSET_BITS = line_offset_bits(BEATS, BEAT_WIDTH);
  localparam int               IDX_W       = beat_idx_width(BEATS);
  localparam int               WIDX_W      = $clog2((BEATS * BEAT_WIDTH) / 32);
  localparam logic [IDX_W-1:0] LAST_BEAT   = IDX_W'(BEATS - 1);

  bridge_state_t   state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic            is_write_q, is_write_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     burst_address_q, burst_address_d;
  logic            burst_read_q, burst_read_d;
  logic            burst_write_q, burst_write_d;
  logic            mem_resp_q, mem_resp_d;
  logic [31:0]     mem_rdata_q, mem_rdata_d;

  logic                  beat_we_s;
  logic                  merge_en_s;
  logic [WIDX_W-1:0]     word_idx_s;
  logic [BEAT_WIDTH-1:0] beat_rdata_s;
  logic [31:0]           word_rdata_s;
  logic                  unused_addr_bits_s;

  assign word_idx_s         = addr_q[OFFSET_BITS-1:2];
  assign unused_addr_bits_s = ^addr_q[1:0];

  line_buffer #(
    .BEATS      (BEATS),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_line_buffer (
    .clk        (clk),
    .rst        (rst),
    .beat_we    (beat_we_s),
    .beat_widx  (cnt_q),
    .beat_wdata (burst_rdata),
    .merge_en   (merge_en_s),
    .word_idx   (word_idx_s),
    .merge_data (wdata_q),
    .merge_be   (be_q),
    .beat_ridx  (cnt_q),
    .beat_rdata (beat_rdata_s),
    .word_rdata (word_rdata_s)
  );

  // FSM next state, beat counter and request capture.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    is_write_d      = is_write_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    be_d            = be_q;
    burst_address_d = burst_address_q;
    beat_we_s       = 1'b0;
    merge_en_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_write || mem_read) begin
          state_d         = RD;
          is_write_d      = mem_write;
          addr_d          = mem_address;
          wdata_d         = mem_wdata;
          be_d            = mem_byte_enable;
          burst_address_d = {mem_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          cnt_d           = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (burst_resp) begin
          beat_we_s = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = is_write_q ? MERGE : DONE;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end else begin
          state_d = RD;
        end
      end
      MERGE: begin
        merge_en_s = 1'b1;
        state_d    = WR;
      end
      WR: begin
        if (burst_resp) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end else begin
          state_d = WR;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Handshake outputs are registered from the next state so they track it exactly.
  always_comb begin
    burst_read_d  = (state_d == RD);
    burst_write_d = (state_d == WR);
    mem_resp_d    = (state_d == DONE);
    mem_rdata_d   = (state_d == DONE) ? word_rdata_s : mem_rdata_q;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      is_write_q      <= 1'b0;
      addr_q          <= 32'h0;
      wdata_q         <= 32'h0;
      be_q            <= 4'h0;
      burst_address_q <= 32'h0;
      burst_read_q    <= 1'b0;
      burst_write_q   <= 1'b0;
      mem_resp_q      <= 1'b0;
      mem_rdata_q     <= 32'h0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      is_write_q      <= is_write_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      be_q            <= be_d;
      burst_address_q <= burst_address_d;
      burst_read_q    <= burst_read_d;
      burst_write_q   <= burst_write_d;
      mem_resp_q      <= mem_resp_d;
      mem_rdata_q     <= mem_rdata_d;
    end
  end

  assign mem_rdata     = mem_rdata_q;
  assign mem_resp      = mem_resp_q;
  assign burst_address = burst_address_q;
  assign burst_read    = burst_read_q;
  assign burst_write   = burst_write_q;
  assign burst_wdata   = burst_write_q ? beat_rdata_s : {BEAT_WIDTH{1'b0}};

endmodule
